// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
// -----------------------------------------------------------------------------
// Moves instructions from the fetch unit into the decode stage through a
// 2-entry IF/ID skid buffer (main entry = head, skid entry = overflow).
// Valid/ready handshakes are used on both sides. The block also:
//   - drives the immediate-format selects (io_ctrl_0..3) for the decoder,
//   - holds the head for one cycle when it depends on a load that has just
//     issued (load-use bubble),
//   - empties itself on a synchronous pipeline flush.
//
// Ports
//   clock, reset          core clock (rising edge), async active-high reset
//   io_flush              synchronous flush (branch mispredict / trap)
//   io_in_valid/ready     fetch-side handshake (ready is registered)
//   io_in_inst/pc         fetched instruction and its PC
//   io_out_valid/ready    decode-side handshake
//   io_out_inst/pc        head instruction and PC (always the main entry)
//   io_ctrl_0..3          S / B / U / J immediate selects (all low = I-type)
//   io_illegal            head opcode unrecognised
//
// Build option
//   DECODE_ILLEGAL_EN     when defined, io_illegal flags unknown head opcodes;
//                         otherwise io_illegal is tied low.
// -----------------------------------------------------------------------------
module decode_issue_ctrl #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_flush,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [INST_W-1:0] io_in_inst,
    input  logic [PC_W-1:0]   io_in_pc,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [INST_W-1:0] io_out_inst,
    output logic [PC_W-1:0]   io_out_pc,
    output logic              io_ctrl_0,
    output logic              io_ctrl_1,
    output logic              io_ctrl_2,
    output logic              io_ctrl_3,
    output logic              io_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // EMPTY: nothing buffered, ONE: main valid, TWO: main and skid valid
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t            state;
    logic [INST_W-1:0] main_inst;
    logic [PC_W-1:0]   main_pc;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;
    logic              in_ready_q;
    logic              ld_pending;
    logic [4:0]        ld_rd;

    logic              main_valid;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              hazard;
    logic              accept;
    logic              issue;
    logic              load_issue;

    assign main_valid = (state != EMPTY);
    assign opcode     = main_inst[6:0];
    assign rd         = main_inst[11:7];
    assign rs1        = main_inst[19:15];
    assign rs2        = main_inst[24:20];

    // Load-use dependency of the head on the load that issued last cycle.
    // rs1 is read by everything except LUI/AUIPC/JAL; rs2 only by R/S/B.
    always_comb begin
        logic rs1_dep;
        logic rs2_dep;
        rs1_dep = (rs1 == ld_rd) &&
                  !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        rs2_dep = (rs2 == ld_rd) &&
                  (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH);
        hazard  = ld_pending && (rs1_dep || rs2_dep);
    end

    assign io_in_ready  = in_ready_q;
    assign io_out_valid = main_valid && !hazard && !io_flush;
    assign io_out_inst  = main_inst;
    assign io_out_pc    = main_pc;

    assign accept     = io_in_valid && in_ready_q && !io_flush;
    assign issue      = io_out_valid && io_out_ready;
    assign load_issue = issue && (opcode == OP_LOAD) && (rd != 5'd0);

    // Immediate-format selects follow the head opcode; gated by main_valid so
    // a stale head after draining never drives a select.
    assign io_ctrl_0 = main_valid && (opcode == OP_STORE);
    assign io_ctrl_1 = main_valid && (opcode == OP_BRANCH);
    assign io_ctrl_2 = main_valid && (opcode == OP_LUI || opcode == OP_AUIPC);
    assign io_ctrl_3 = main_valid && (opcode == OP_JAL);

    // The illegal flag is informational only; flagged instructions still
    // issue like any other.
    always_comb begin
        io_illegal = 1'b0;
`ifdef DECODE_ILLEGAL_EN
        case (opcode)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_FENCE: io_illegal = 1'b0;
            default:                                        io_illegal = main_valid;
        endcase
`endif
    end

    // Buffer sequencing. Flush wins over any simultaneous accept/issue and
    // also drops a pending load-use bubble. in_ready_q is kept equal to
    // "skid entry not valid" for the next cycle, so fetch never sees a
    // combinational path from io_out_ready. A TWO-state accept cannot happen
    // because in_ready_q is low there.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            main_inst  <= '0;
            main_pc    <= '0;
            skid_inst  <= '0;
            skid_pc    <= '0;
            in_ready_q <= 1'b1;
            ld_pending <= 1'b0;
            ld_rd      <= 5'd0;
        end else if (io_flush) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            ld_pending <= 1'b0;
        end else begin
            ld_pending <= load_issue;
            if (load_issue) begin
                ld_rd <= rd;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_inst <= io_in_inst;
                        main_pc   <= io_in_pc;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !issue) begin
                        skid_inst  <= io_in_inst;
                        skid_pc    <= io_in_pc;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (accept && issue) begin
                        main_inst <= io_in_inst;
                        main_pc   <= io_in_pc;
                    end else if (issue) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (issue) begin
                        main_inst  <= skid_inst;
                        main_pc    <= skid_pc;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl
// -----------------------------------------------------------------------------
// Scoreboard bench for decode_issue_ctrl. Accepted instructions are queued in
// program order; a negedge monitor compares the head, the handshakes, the
// immediate selects and the load-use bubble against a queue-based model of
// the intended behaviour. Directed sequences are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_decode_issue_ctrl;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_flush;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_in_inst;
    logic [31:0] io_in_pc;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_inst;
    logic [31:0] io_out_pc;
    logic        io_ctrl_0;
    logic        io_ctrl_1;
    logic        io_ctrl_2;
    logic        io_ctrl_3;
    logic        io_illegal;

    int    checks = 0;
    int    errors = 0;
    item_t sb_q[$];

    bit          pend_valid;
    logic [4:0]  pend_rd;
    bit          acc_pend;
    item_t       acc_item;
    bit          flush_seen;
    bit          have;
    bit          hz;
    bit          exp_valid;
    bit          exp_ill;
    int          occ;
    item_t       head;
    logic [31:0] pc_ctr;

    decode_issue_ctrl #(.INST_W(32), .PC_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_flush    (io_flush),
        .io_in_valid (io_in_valid),
        .io_in_ready (io_in_ready),
        .io_in_inst  (io_in_inst),
        .io_in_pc    (io_in_pc),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_out_inst (io_out_inst),
        .io_out_pc   (io_out_pc),
        .io_ctrl_0   (io_ctrl_0),
        .io_ctrl_1   (io_ctrl_1),
        .io_ctrl_2   (io_ctrl_2),
        .io_ctrl_3   (io_ctrl_3),
        .io_illegal  (io_illegal)
    );

    always #5 clock = ~clock;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input bit v, input logic [31:0] inst,
                                 input logic [31:0] pc, input bit ordy,
                                 input bit fl);
        @(posedge clock);
        #1;
        io_in_valid  = v;
        io_in_inst   = inst;
        io_in_pc     = pc;
        io_out_ready = ordy;
        io_flush     = fl;
    endtask

    // Expected immediate selects as {J, U, B, S}.
    function automatic logic [3:0] exp_ctrl(input logic [31:0] inst);
        case (inst[6:0])
            7'b0100011:             return 4'b0001;
            7'b1100011:             return 4'b0010;
            7'b0110111, 7'b0010111: return 4'b0100;
            7'b1101111:             return 4'b1000;
            default:                return 4'b0000;
        endcase
    endfunction

`ifdef DECODE_ILLEGAL_EN
    function automatic bit is_legal(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011,
            7'b0001111: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction
`endif

    // Does instruction inst read register r as a source?
    function automatic bit depends(input logic [31:0] inst, input logic [4:0] r);
        logic [6:0] op;
        bit         uses1;
        bit         uses2;
        op    = inst[6:0];
        uses1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        uses2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        return (uses1 && inst[19:15] == r) || (uses2 && inst[24:20] == r);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [13];
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                7'b1110011, 7'b0001111, 7'b1111111};
        op  = ops[$urandom_range(0, 12)];
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        return {7'($urandom_range(0, 127)), rs2, rs1,
                3'($urandom_range(0, 7)), rd, op};
    endfunction

    // Monitor: compares DUT outputs with the model once per cycle, retires
    // the head on an issue and records what will be accepted at the next edge.
    always @(negedge clock) begin
        if (reset) begin
            pend_valid = 1'b0;
            acc_pend   = 1'b0;
            flush_seen = 1'b0;
        end else begin
            occ  = sb_q.size();
            have = (occ > 0);
            if (have) head = sb_q[0];
            else      head = '0;
            hz        = pend_valid && have && depends(head.inst, pend_rd);
            exp_valid = have && !hz && !io_flush;
            checkOutput("out_valid", 64'(io_out_valid), 64'(exp_valid));
            checkOutput("in_ready", 64'(io_in_ready), 64'(occ < 2));
`ifdef DECODE_ILLEGAL_EN
            exp_ill = have && !is_legal(head.inst[6:0]);
`else
            exp_ill = 1'b0;
`endif
            checkOutput("illegal", 64'(io_illegal), 64'(exp_ill));
            if (have) begin
                checkOutput("head_inst", 64'(io_out_inst), 64'(head.inst));
                checkOutput("head_pc", 64'(io_out_pc), 64'(head.pc));
                checkOutput("ctrl", 64'({io_ctrl_3, io_ctrl_2, io_ctrl_1, io_ctrl_0}),
                            64'(exp_ctrl(head.inst)));
            end else begin
                checkOutput("ctrl_empty",
                            64'({io_ctrl_3, io_ctrl_2, io_ctrl_1, io_ctrl_0}), 64'(0));
            end
            pend_valid = 1'b0;
            if (exp_valid && io_out_ready) begin
                head = sb_q.pop_front();
                if (head.inst[6:0] == 7'b0000011 && head.inst[11:7] != 5'd0) begin
                    pend_valid = 1'b1;
                    pend_rd    = head.inst[11:7];
                end
            end
            acc_pend      = io_in_valid && (occ < 2) && !io_flush;
            acc_item.inst = io_in_inst;
            acc_item.pc   = io_in_pc;
            flush_seen    = io_flush;
        end
    end

    // Edge-side model update: flush or reset empties the queue, otherwise the
    // instruction seen accepted in the previous half cycle is appended.
    always @(posedge clock) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (flush_seen)    sb_q.delete();
            else if (acc_pend) sb_q.push_back(acc_item);
            acc_pend   = 1'b0;
            flush_seen = 1'b0;
        end
    end

    initial begin
        reset        = 1'b1;
        io_flush     = 1'b0;
        io_in_valid  = 1'b1;
        io_in_inst   = 32'h00500093;
        io_in_pc     = 32'h0;
        io_out_ready = 1'b1;
        pc_ctr       = 32'h1000;

        // Reset held with fetch offering an instruction
        #12;
        checkOutput("rst_out_valid", 64'(io_out_valid), 64'(0));
        checkOutput("rst_in_ready", 64'(io_in_ready), 64'(1));
        checkOutput("rst_ctrl", 64'({io_ctrl_3, io_ctrl_2, io_ctrl_1, io_ctrl_0}), 64'(0));
        checkOutput("rst_illegal", 64'(io_illegal), 64'(0));
        checkOutput("rst_out_inst", 64'(io_out_inst), 64'(0));
        checkOutput("rst_out_pc", 64'(io_out_pc), 64'(0));
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        reset       = 1'b0;

        // addi after reset
        applyStimulus(1, 32'h00500093, 32'h100, 1, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);

        // Fill with downstream stalled, third one waits, then drain in order
        applyStimulus(1, 32'h00100113, 32'h200, 0, 0);
        applyStimulus(1, 32'h00200193, 32'h204, 0, 0);
        applyStimulus(1, 32'h00300213, 32'h208, 0, 0);
        applyStimulus(1, 32'h00300213, 32'h208, 0, 0);
        applyStimulus(1, 32'h00300213, 32'h208, 1, 0);
        applyStimulus(1, 32'h00300213, 32'h208, 1, 0);
        repeat (3) applyStimulus(0, 32'h0, 32'h0, 1, 0);

        // Load-use with dependency, then without
        applyStimulus(1, 32'h0000A103, 32'h300, 1, 0);
        applyStimulus(1, 32'h002081B3, 32'h304, 1, 0);
        repeat (4) applyStimulus(0, 32'h0, 32'h0, 1, 0);
        applyStimulus(1, 32'h0000A103, 32'h310, 1, 0);
        applyStimulus(1, 32'h004081B3, 32'h314, 1, 0);
        repeat (4) applyStimulus(0, 32'h0, 32'h0, 1, 0);

        // One of each immediate format
        applyStimulus(1, 32'h0020A023, 32'h400, 1, 0);
        applyStimulus(1, 32'h00208063, 32'h404, 1, 0);
        applyStimulus(1, 32'h123450B7, 32'h408, 1, 0);
        applyStimulus(1, 32'h008000EF, 32'h40C, 1, 0);
        repeat (3) applyStimulus(0, 32'h0, 32'h0, 1, 0);

        // Flush while full, with a new instruction offered the same cycle
        applyStimulus(1, 32'h00100093, 32'h500, 0, 0);
        applyStimulus(1, 32'h00200093, 32'h504, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 0, 0);
        applyStimulus(1, 32'h00300093, 32'h508, 1, 1);
        repeat (3) applyStimulus(0, 32'h0, 32'h0, 1, 0);

        // Unknown opcode still flows through
        applyStimulus(1, 32'h0000007F, 32'h600, 1, 0);
        repeat (3) applyStimulus(0, 32'h0, 32'h0, 1, 0);

        // Reset in the middle of buffered traffic
        applyStimulus(1, 32'h00100093, 32'h700, 0, 0);
        applyStimulus(1, 32'h00200093, 32'h704, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 64'(io_out_valid), 64'(0));
        checkOutput("midrst_in_ready", 64'(io_in_ready), 64'(1));
        checkOutput("midrst_ctrl", 64'({io_ctrl_3, io_ctrl_2, io_ctrl_1, io_ctrl_0}), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) applyStimulus(0, 32'h0, 32'h0, 1, 0);

        // Random traffic with hazards, stalls and occasional flushes
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, rand_inst(), pc_ctr,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
            pc_ctr = pc_ctr + 32'd4;
        end

        // Drain
        repeat (6) applyStimulus(0, 32'h0, 32'h0, 1, 0);
        @(negedge clock);
        #1;
        checkOutput("drain_out_valid", 64'(io_out_valid), 64'(0));
        checkOutput("drain_in_ready", 64'(io_in_ready), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
